seletor_bebida: RTL

//  Drink-selection front end of the coffee machine and source of the 2-bit code read by the S2 display decoder.

---
 rtl/seletor_bebida.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seletor_bebida.sv
// rtl/seletor_bebida.sv - drink selection front end: button debounce, wrap-around code, request handshake
// Bit 0 of the button vectors is "advance", bit 1 is "confirm".
module seletor_bebida #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 64,
  parameter int NUM_OPCOES      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_avancar,
  input  logic       botao_confirmar,
  input  logic       pedido_aceito,
  input  logic       ocupado,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic       pedido_valido,
  output logic [1:0] pedido_codigo,
  output logic       travado
);

  localparam int DCW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int IW  = $clog2(TIMEOUT_CICLOS);

  typedef enum logic [1:0] {
    SELECIONANDO = 2'd0,
    PEDINDO      = 2'd1,
    PREPARANDO   = 2'd2
  } estado_t;

  estado_t             state, state_next;
  logic [1:0]          sync1, sync2, filt, filt_q;
  logic [1:0][DCW-1:0] dcnt;
  logic [1:0]          ev;
  logic                ev_av, ev_cf;
  logic [1:0]          code, code_inc;
  logic [IW-1:0]       idle;

  // Synchronizers and debounce filters; the filtered level moves only after
  // DEBOUNCE_CICLOS consecutive disagreeing cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_q <= '0;
      dcnt   <= '0;
    end else begin
      sync1  <= {botao_confirmar, botao_avancar};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCW'(DEBOUNCE_CICLOS - 1)) begin
          filt[i] <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DCW'(1);
        end
      end
    end
  end

  assign ev    = filt & ~filt_q;
  assign ev_av = ev[0];
  assign ev_cf = ev[1];

  assign code_inc = (code == 2'(NUM_OPCOES - 1)) ? 2'd0 : code + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SELECIONANDO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SELECIONANDO: if (ev_cf && !ocupado) state_next = PEDINDO;
      PEDINDO:      if (pedido_aceito)     state_next = PREPARANDO;
      PREPARANDO:   if (!ocupado)          state_next = SELECIONANDO;
      default:                             state_next = SELECIONANDO;
    endcase
  end

  // Code, idle timer and latched request code. Confirm has priority over
  // advance, and an advance event has priority over the idle timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code          <= '0;
      idle          <= '0;
      pedido_codigo <= '0;
    end else if (state == SELECIONANDO) begin
      if (ev_cf && !ocupado) begin
        pedido_codigo <= code;
        idle          <= '0;
      end else if (ev_av) begin
        code <= code_inc;
        idle <= '0;
      end else if (ev_cf) begin
        idle <= '0;
      end else if (idle == IW'(TIMEOUT_CICLOS - 1)) begin
        code <= '0;
        idle <= '0;
      end else begin
        idle <= idle + IW'(1);
      end
    end else begin
      idle <= '0;
    end
  end

  always_comb begin
    pedido_valido  = (state == PEDINDO);
    travado        = (state != SELECIONANDO) || ocupado;
    saida1Contador = code[1];
    saida2Contador = code[0];
  end

endmodule
